// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// ALU operations and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL, FAULT
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_PC4     = 2'd2;

    localparam logic [1:0] PC_ALURESULT = 2'd0;
    localparam logic [1:0] PC_ALUOUT    = 2'd1;
    localparam logic [1:0] PC_JALR      = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decode from the FSM's ALU class and the IR function fields.
// Latency: combinational. Backpressure: none.
// funct7[5] picks SUB/SRA on R-type; on I-type only funct3=101 honours it (SRAI).
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  aluop_t     aluop,
    output logic [3:0] alu_ctrl
);

    logic alt;
    logic unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alt      = funct7[5] & ((op == OP_RTYPE) | (funct3 == 3'b101));
        alu_ctrl = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = alt ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM driving the shared-memory datapath.
// Latency: branch/jump 3 cycles, ALU/store 4, load 5 (mem_ready=1).
// Backpressure: FETCH/MEMREAD/MEMWRITE stall on mem_ready; MEM_TIMEOUT stalled cycles -> FAULT.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W    = 4,
    parameter int MEM_TIMEOUT   = 16,
    parameter bit SUPPORT_AUIPC = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  Zero,
    input  logic                  LT,
    input  logic                  LTU,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic [1:0]            PCSrc,
    output logic                  AdrSrc,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [2:0]            MemSrc,
    output logic                  IRWrite,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [2:0]            ImmSrc,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic                  illegal,
    output logic                  mem_fault,
    output logic [3:0]            state_o
);

    localparam int CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

    state_t          state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic            mem_wait, timeout;
    aluop_t          aluop;
    logic [3:0]      alu_dec;

    assign state_o    = state;
    assign ALUControl = ALU_CTRL_W'(alu_dec);

    assign mem_wait = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !mem_ready;
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == CNT_LAST);

    alu_decoder u_alu_decoder (
        .op       (op),
        .funct3   (funct3),
        .funct7   (funct7),
        .aluop    (aluop),
        .alu_ctrl (alu_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || !mem_wait)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (state_nxt == ILLEGAL)
                illegal <= 1'b1;
            if (timeout)
                mem_fault <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        PCWrite   = 1'b0;
        PCSrc     = PC_ALURESULT;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemSrc    = 3'd0;
        IRWrite   = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        aluop     = ALUOP_ADD;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                // ALUOut <= OldPC + imm: branch target, or jump target for JAL
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_RTYPE:          state_nxt = EXECR;
                    OP_ITYPE:          state_nxt = EXECI;
                    OP_BRANCH:         state_nxt = BRANCH;
                    OP_JAL:            state_nxt = JAL;
                    OP_JALR:           state_nxt = JALR;
                    OP_LUI:            state_nxt = LUI;
                    OP_AUIPC:          state_nxt = SUPPORT_AUIPC ? AUIPC : ILLEGAL;
                    default:           state_nxt = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = (op == OP_STORE) ? IMM_S : IMM_I;
                MemSrc    = funct3;
                state_nxt = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                MemSrc  = funct3;
                if (mem_ready) state_nxt = MEMWB;
            end
            MEMWB: begin
                MemSrc    = funct3;
                ResultSrc = RES_MEMDATA;
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                MemSrc   = funct3;
                if (mem_ready) state_nxt = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = (state == EXECI) ? SRCB_IMM : SRCB_RS2;
                aluop     = ALUOP_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                aluop     = ALUOP_SUB;
                PCSrc     = PC_ALUOUT;
                state_nxt = FETCH;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = !Zero;
                    3'b100:  PCWrite = LT;
                    3'b101:  PCWrite = !LT;
                    3'b110:  PCWrite = LTU;
                    3'b111:  PCWrite = !LTU;
                    default: state_nxt = ILLEGAL;
                endcase
            end
            JAL: begin
                PCSrc     = PC_ALUOUT;
                PCWrite   = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = RES_PC4;
                state_nxt = FETCH;
            end
            JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                PCSrc     = PC_JALR;
                PCWrite   = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = RES_PC4;
                state_nxt = FETCH;
            end
            LUI, AUIPC: begin
                ALUSrcA   = (state == LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_U;
                state_nxt = ALUWB;
            end
            default: state_nxt = state;
        endcase
        if (timeout) state_nxt = FAULT;
        // Enables are cut combinationally so an in-flight access dies the cycle rst is seen
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboarded bench for multicycle_control_unit: per-cycle expected control
// vectors are queued with their mem_ready stimulus and compared at negedge.
module tb_multicycle_control_unit;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_XOR = 4'd4, A_SLTU = 4'd6,
                           A_SRL = 4'd8, A_SRA = 4'd9;
    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMREAD = 4'd3,
                           ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5, ST_EXECR = 4'd6, ST_EXECI = 4'd7,
                           ST_ALUWB = 4'd8, ST_BRANCH = 4'd9, ST_JAL = 4'd10, ST_JALR = 4'd11,
                           ST_LUI = 4'd12, ST_AUIPC = 4'd13, ST_ILLEGAL = 4'd14, ST_FAULT = 4'd15;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, mr, mw, rw, adr;
        logic [1:0] pcsrc, asa, asb;
        logic [2:0] imm;
        logic [1:0] rsrc;
        logic [2:0] msrc;
        logic [3:0] aluc;
    } ctl_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] st;
        logic [1:0] asa, asb;
        logic [2:0] imm;
        logic [3:0] aluc;
    } alu_vec_t;

    typedef struct packed {
        logic [2:0] f3;
        logic       z, lt, ltu, taken;
    } br_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       Zero = 1'b0, LT = 1'b0, LTU = 1'b0, mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, illegal, mem_fault;
    logic [1:0] PCSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] MemSrc, ImmSrc;
    logic [3:0] ALUControl, state_o;

    ctl_t exp_q[$];
    logic rdy_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_TIMEOUT(16), .SUPPORT_AUIPC(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .AdrSrc(AdrSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemSrc(MemSrc), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .illegal(illegal), .mem_fault(mem_fault), .state_o(state_o)
    );

    function automatic ctl_t c(input logic [3:0] st, input logic pcw, irw, mr, mw, rw, adr,
                               input logic [1:0] pcsrc, asa, asb, input logic [2:0] imm,
                               input logic [1:0] rsrc, input logic [2:0] msrc, input logic [3:0] aluc);
        ctl_t r;
        r.st = st; r.pcw = pcw; r.irw = irw; r.mr = mr; r.mw = mw; r.rw = rw; r.adr = adr;
        r.pcsrc = pcsrc; r.asa = asa; r.asb = asb; r.imm = imm; r.rsrc = rsrc;
        r.msrc = msrc; r.aluc = aluc;
        return r;
    endfunction

    // MemSrc is only meaningful while an access is on the bus
    function automatic ctl_t got();
        ctl_t g;
        g = c(state_o, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc,
              PCSrc, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, MemSrc, ALUControl);
        if (state_o != ST_MEMREAD && state_o != ST_MEMWRITE) g.msrc = 3'd0;
        return g;
    endfunction

    task automatic push(input ctl_t e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    task automatic push_fd(input logic [2:0] dec_imm);
        push(c(ST_FETCH, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 2'd0, 3'd0, A_ADD), 1'b1);
        push(c(ST_DECODE, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, dec_imm, 2'd0, 3'd0, A_ADD), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== 5'b0) begin
            errors++; $display("FAIL reset_enables got %b want 00000", {PCWrite, IRWrite, MemRead, MemWrite, RegWrite});
        end
        checks++;
        if (state_o !== ST_FETCH || illegal !== 1'b0 || mem_fault !== 1'b0) begin
            errors++; $display("FAIL reset_state got st=%0d ill=%b flt=%b want st=0 ill=0 flt=0", state_o, illegal, mem_fault);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        alu_vec_t tv[$];
        ctl_t e, g;
        int n;
        tv.push_back('{7'b0110011, 3'b000, 7'b0000000, ST_EXECR, 2'd2, 2'd0, 3'd0, A_ADD});
        tv.push_back('{7'b0110011, 3'b000, 7'b0100000, ST_EXECR, 2'd2, 2'd0, 3'd0, A_SUB});
        tv.push_back('{7'b0110011, 3'b100, 7'b0000000, ST_EXECR, 2'd2, 2'd0, 3'd0, A_XOR});
        tv.push_back('{7'b0110011, 3'b011, 7'b0000000, ST_EXECR, 2'd2, 2'd0, 3'd0, A_SLTU});
        tv.push_back('{7'b0010011, 3'b101, 7'b0100000, ST_EXECI, 2'd2, 2'd1, 3'd0, A_SRA});
        tv.push_back('{7'b0010011, 3'b101, 7'b0000000, ST_EXECI, 2'd2, 2'd1, 3'd0, A_SRL});
        tv.push_back('{7'b0010011, 3'b000, 7'b0100000, ST_EXECI, 2'd2, 2'd1, 3'd0, A_ADD});
        tv.push_back('{7'b0110111, 3'b101, 7'b0100000, ST_LUI,   2'd3, 2'd1, 3'd4, A_ADD});
        tv.push_back('{7'b0010111, 3'b000, 7'b0000000, ST_AUIPC, 2'd1, 2'd1, 3'd4, A_ADD});
        foreach (tv[i]) begin
            op = tv[i].op; funct3 = tv[i].f3; funct7 = tv[i].f7;
            push_fd(3'd1);
            push(c(tv[i].st, 0, 0, 0, 0, 0, 0, 2'd0, tv[i].asa, tv[i].asb, tv[i].imm, 2'd0, 3'd0, tv[i].aluc), 1'b1);
            push(c(ST_ALUWB, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, A_ADD), 1'b1);
            n = 0;
            while (exp_q.size() > 0) begin
                mem_ready = rdy_q.pop_front();
                @(negedge clk);
                e = exp_q.pop_front(); g = got(); checks++;
                if (g !== e) begin errors++; $display("FAIL alu[%0d] cyc%0d got %h want %h", i, n, g, e); end
                n++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load_store();
        ctl_t e, g;
        int n;
        op = 7'b0000011; funct3 = 3'b100; funct7 = 7'd0;
        push_fd(3'd1);
        push(c(ST_MEMADR, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 3'd0, A_ADD), 1'b1);
        for (int k = 0; k < 4; k++)
            push(c(ST_MEMREAD, 0, 0, 1, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd4, A_ADD), k == 3);
        push(c(ST_MEMWB, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd1, 3'd0, A_ADD), 1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL lbu cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
        op = 7'b0100011; funct3 = 3'b010;
        push_fd(3'd1);
        push(c(ST_MEMADR, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd2, 2'd0, 3'd0, A_ADD), 1'b1);
        push(c(ST_MEMWRITE, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd2, A_ADD), 1'b1);
        push(c(ST_FETCH, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 2'd0, 3'd0, A_ADD), 1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL sw cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
        // DUT is now in DECODE of the next fetched word; finish it as an ALU op
        op = 7'b0110011; funct3 = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_branch();
        br_vec_t bv[$];
        ctl_t e, g;
        int n;
        bv.push_back('{3'b000, 1'b1, 1'b0, 1'b0, 1'b1});
        bv.push_back('{3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
        bv.push_back('{3'b001, 1'b0, 1'b0, 1'b0, 1'b1});
        bv.push_back('{3'b001, 1'b1, 1'b0, 1'b0, 1'b0});
        bv.push_back('{3'b110, 1'b0, 1'b0, 1'b1, 1'b1});
        bv.push_back('{3'b110, 1'b0, 1'b1, 1'b0, 1'b0});
        bv.push_back('{3'b101, 1'b0, 1'b1, 1'b0, 1'b0});
        bv.push_back('{3'b101, 1'b0, 1'b0, 1'b0, 1'b1});
        bv.push_back('{3'b100, 1'b0, 1'b1, 1'b0, 1'b1});
        bv.push_back('{3'b111, 1'b0, 1'b0, 1'b1, 1'b0});
        op = 7'b1100011; funct7 = 7'd0;
        foreach (bv[i]) begin
            funct3 = bv[i].f3; Zero = bv[i].z; LT = bv[i].lt; LTU = bv[i].ltu;
            push_fd(3'd1);
            push(c(ST_BRANCH, bv[i].taken, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0, 2'd0, 3'd0, A_SUB), 1'b1);
            n = 0;
            while (exp_q.size() > 0) begin
                mem_ready = rdy_q.pop_front();
                @(negedge clk);
                e = exp_q.pop_front(); g = got(); checks++;
                if (g !== e) begin errors++; $display("FAIL branch[%0d] cyc%0d got %h want %h", i, n, g, e); end
                n++;
                @(posedge clk); #1;
            end
        end
        Zero = 1'b0; LT = 1'b0; LTU = 1'b0;
    endtask

    task automatic test_jump();
        ctl_t e, g;
        int n;
        op = 7'b1100111; funct3 = 3'b000; funct7 = 7'd0;
        push_fd(3'd1);
        push(c(ST_JALR, 1, 0, 0, 0, 1, 0, 2'd2, 2'd2, 2'd1, 3'd0, 2'd2, 3'd0, A_ADD), 1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL jalr cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
        op = 7'b1101111;
        push_fd(3'd3);
        push(c(ST_JAL, 1, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 3'd0, 2'd2, 3'd0, A_ADD), 1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL jal cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        ctl_t e, g;
        int n;
        op = 7'b1111111; funct3 = 3'b000; funct7 = 7'd0;
        push_fd(3'd1);
        for (int k = 0; k < 20; k++)
            push(c(ST_ILLEGAL, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, A_ADD), 1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL illegal_op cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b want 1", illegal); end
        do_reset();
        @(negedge clk);
        checks++;
        if (state_o !== ST_FETCH || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_clear got st=%0d ill=%b want st=0 ill=0", state_o, illegal);
        end
        @(posedge clk); #1;
        op = 7'b1100011; funct3 = 3'b010;
        push_fd(3'd1);
        push(c(ST_BRANCH, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0, 2'd0, 3'd0, A_SUB), 1'b1);
        push(c(ST_ILLEGAL, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, A_ADD), 1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL illegal_br cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_br_flag got %b want 1", illegal); end
        do_reset();
    endtask

    task automatic test_timeout();
        ctl_t e, g;
        int n;
        op = 7'b0110011; funct3 = 3'b000; funct7 = 7'd0;
        for (int k = 0; k < 16; k++)
            push(c(ST_FETCH, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, A_ADD), 1'b0);
        for (int k = 0; k < 3; k++)
            push(c(ST_FAULT, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, A_ADD), 1'b0);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL timeout cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (mem_fault !== 1'b1) begin errors++; $display("FAIL mem_fault got %b want 1", mem_fault); end
        do_reset();
        op = 7'b0100011; funct3 = 3'b000;
        push_fd(3'd1);
        push(c(ST_MEMADR, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd2, 2'd0, 3'd0, A_ADD), 1'b1);
        push(c(ST_MEMWRITE, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, A_ADD), 1'b0);
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front(); g = got(); checks++;
            if (g !== e) begin errors++; $display("FAIL sb_pre_rst cyc%0d got %h want %h", n, g, e); end
            n++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b0 || state_o !== ST_MEMWRITE) begin
            errors++; $display("FAIL rst_drop_write got mw=%b st=%0d want mw=0 st=5", MemWrite, state_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (state_o !== ST_FETCH || mem_fault !== 1'b0) begin
            errors++; $display("FAIL rst_after_store got st=%0d flt=%b want st=0 flt=0", state_o, mem_fault);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jump();
        test_illegal();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
